ifetch_ctrl: RTL

//  Instruction-fetch sequencer feeding the decoder. Owns the PC and issues word fetches to

---
 rtl/ifetch_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction-fetch sequencer: PC, single-outstanding imem fetch, 2-entry decode FIFO
module ifetch_ctrl #(
    parameter int             W        = 32,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [W-1:0] imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [W-1:0] imem_rdata,
    input  logic         redirect,
    input  logic [W-1:0] redirect_pc,
    output logic         inst_valid,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc,
    input  logic         inst_ready
);

    typedef enum logic {S_REQ, S_WAIT} state_t;

    localparam logic [W-1:0] ALIGN_MASK = ~{{(W-2){1'b0}}, 2'b11};

    state_t       state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] inflight_pc_q, inflight_pc_d;
    logic         drop_q, drop_d;
    logic [1:0]   count_q, count_d;
    logic [W-1:0] e0_inst_q, e0_inst_d, e0_pc_q, e0_pc_d;
    logic [W-1:0] e1_inst_q, e1_inst_d, e1_pc_q, e1_pc_d;

    logic req;
    logic push;
    logic pop;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        drop_d        = drop_q;
        count_d       = count_q;
        e0_inst_d     = e0_inst_q;
        e0_pc_d       = e0_pc_q;
        e1_inst_d     = e1_inst_q;
        e1_pc_d       = e1_pc_q;

        // Issuing only with a free slot guarantees the response always has room.
        req  = (state_q == S_REQ) && (count_q != 2'd2) && !redirect;
        pop  = (count_q != 2'd0) && inst_ready && !redirect;
        push = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect;

        case (state_q)
            S_REQ: begin
                if (req && imem_gnt) begin
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + W'(4);
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (redirect) begin
            pc_d    = redirect_pc & ALIGN_MASK;
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_inst_d = imem_rdata;
                        e0_pc_d   = inflight_pc_q;
                    end else begin
                        e1_inst_d = imem_rdata;
                        e1_pc_d   = inflight_pc_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_inst_d = e1_inst_q;
                    e0_pc_d   = e1_pc_q;
                    count_d   = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_inst_d = imem_rdata;
                        e0_pc_d   = inflight_pc_q;
                    end else begin
                        e0_inst_d = e1_inst_q;
                        e0_pc_d   = e1_pc_q;
                        e1_inst_d = imem_rdata;
                        e1_pc_d   = inflight_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            drop_q        <= 1'b0;
            count_q       <= 2'd0;
            e0_inst_q     <= '0;
            e0_pc_q       <= '0;
            e1_inst_q     <= '0;
            e1_pc_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            e0_inst_q     <= e0_inst_d;
            e0_pc_q       <= e0_pc_d;
            e1_inst_q     <= e1_inst_d;
            e1_pc_q       <= e1_pc_d;
        end
    end

    // Outputs are forced quiet while reset is held, even before the first edge.
    assign imem_req   = !rst && req;
    assign imem_addr  = rst ? RESET_PC : pc_q;
    assign inst_valid = !rst && (count_q != 2'd0);
    assign inst       = rst ? '0 : e0_inst_q;
    assign inst_pc    = rst ? '0 : e0_pc_q;

endmodule
